// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin share of one serial frame transmitter among
// NREQ result sources, with send/ack handshake, ack timeout and frame gap.
module tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int GAP     = 72,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*40-1:0] req_data,
  input  logic [NREQ*8-1:0] req_id,
  output logic [NREQ-1:0]   grant,
  output logic [39:0]       tx_din,
  output logic [7:0]        tx_device_id,
  output logic              tx_send,
  input  logic              tx_ack,
  output logic              busy,
  output logic              err
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RELEASE,
    S_GAP
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   win;
  logic [PW-1:0]   win_nxt;
  logic            found;
  logic [NREQ-1:0] win_oh;

  // Descending scan so the requester closest to ptr wins last.
  always_comb begin
    int j;
    j     = 0;
    win   = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win   = PW'(j);
        found = 1'b1;
      end
    end
  end

  assign win_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  assign win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= S_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      grant        <= '0;
      tx_din       <= '0;
      tx_device_id <= '0;
      tx_send      <= 1'b0;
      err          <= 1'b0;
    end else begin
      grant <= '0;
      err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            tx_din       <= req_data[40*int'(win) +: 40];
            tx_device_id <= req_id[8*int'(win) +: 8];
            tx_send      <= 1'b1;
            grant        <= win_oh;
            ptr          <= win_nxt;
            cnt          <= '0;
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ack) begin
            tx_send <= 1'b0;
            state   <= S_RELEASE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            tx_send <= 1'b0;
            err     <= 1'b1;
            cnt     <= CW'(GAP - 1);
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!tx_ack) begin
            cnt   <= CW'(GAP - 1);
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_IDLE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter; grants are checked
// against queued expectations, timing checked inline per scenario.
module tb_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int GAP     = 72;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              clr;
  logic [NREQ-1:0]   req;
  logic [NREQ*40-1:0] req_data;
  logic [NREQ*8-1:0] req_id;
  logic [NREQ-1:0]   grant;
  logic [39:0]       tx_din;
  logic [7:0]        tx_device_id;
  logic              tx_send;
  logic              tx_ack;
  logic              busy;
  logic              err;

  logic ack_en;
  logic send_q;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   grant_total = 0;
  bit   send_prev = 1'b0;

  typedef struct packed {
    logic [3:0]  g;
    logic [39:0] d;
    logic [7:0]  id;
  } exp_t;

  exp_t sb[$];
  int   rise_q[$];
  exp_t e;

  tx_arbiter #(
    .NREQ(NREQ),
    .GAP(GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .clr(clr),
    .req(req),
    .req_data(req_data),
    .req_id(req_id),
    .grant(grant),
    .tx_din(tx_din),
    .tx_device_id(tx_device_id),
    .tx_send(tx_send),
    .tx_ack(tx_ack),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: ack seen by the arbiter two edges after send rises,
  // and withdrawn as soon as send drops.
  always @(posedge clk or posedge clr)
    if (clr) send_q <= 1'b0;
    else send_q <= tx_send;

  assign tx_ack = ack_en & tx_send & send_q;

  always @(negedge clk) begin
    if (tx_send === 1'b1 && !send_prev) rise_q.push_back(cyc);
    send_prev = (tx_send === 1'b1);
    if (clr === 1'b0 && grant !== '0) begin
      grant_total++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected grant=%b required none", grant);
      end else begin
        e = sb.pop_front();
        if (grant !== e.g || tx_din !== e.d || tx_device_id !== e.id) begin
          errors++;
          $display("FAIL sb_grant got grant=%b din=%h id=%h required grant=%b din=%h id=%h",
                   grant, tx_din, tx_device_id, e.g, e.d, e.id);
        end
      end
      checks++;
      if (tx_send !== 1'b1) begin
        errors++;
        $display("FAIL send_with_grant got %b required 1", tx_send);
      end
    end
  end

  function automatic exp_t mk(input int i);
    exp_t x;
    x.g  = 4'b0001 << i;
    x.d  = req_data[40*i +: 40];
    x.id = req_id[8*i +: 8];
    return x;
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve(input int n, input int budget, output int got);
    got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (grant !== '0) begin
        req = req & ~grant;
        got++;
        if (got == n) break;
      end
    end
  endtask

  task automatic reset_dut;
    clr    = 1'b1;
    req    = '0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < NREQ; i++) begin
      req_data[40*i +: 40] = {8'(8'hD0 + i), 32'hCAFE_0000 + 32'(i)};
      req_id[8*i +: 8]     = 8'(8'h10 + i);
    end
    clr    = 1'b1;
    req    = '0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== '0 || tx_send !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got grant=%b send=%b err=%b busy=%b required 0",
               grant, tx_send, err, busy);
    end
    checks++;
    if (tx_din !== 40'h0 || tx_device_id !== 8'h0) begin
      errors++;
      $display("FAIL reset_data got din=%h id=%h required 0", tx_din, tx_device_id);
    end
    clr = 1'b0;
  endtask

  task automatic test_single;
    bit ok;
    int lat;
    int got;
    req_data[40 +: 40] = 40'h12_3456_789A;
    req_id[8 +: 8]     = 8'hC3;
    sb.push_back(mk(1));
    req[1] = 1'b1;
    lat = -1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (grant !== '0) begin
        lat = k;
        break;
      end
    end
    req[1] = 1'b0;
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL single_latency got %0d required 0", lat);
    end
    checks++;
    if (grant !== 4'b0010 || tx_din !== 40'h12_3456_789A || tx_device_id !== 8'hC3) begin
      errors++;
      $display("FAIL single_grant got grant=%b din=%h id=%h required 0010 123456789a c3",
               grant, tx_din, tx_device_id);
    end
    @(negedge clk);
    checks++;
    if (grant !== '0 || tx_send !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_cycle1 got grant=%b send=%b busy=%b required 0000 1 1",
               grant, tx_send, busy);
    end
    @(negedge clk);
    checks++;
    if (tx_send !== 1'b0) begin
      errors++;
      $display("FAIL single_send_drop got %b required 0", tx_send);
    end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_idle got busy required idle");
    end
    // Pointer now at 2: requesters 0 and 2 pending must serve 2 first.
    sb.push_back(mk(2));
    sb.push_back(mk(0));
    req = 4'b0101;
    serve(2, 400, got);
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL ptr_after_single got %0d grants required 2", got);
    end
    wait_idle(200, ok);
  endtask

  task automatic test_round_robin;
    bit ok;
    int got;
    reset_dut();
    rise_q.delete();
    sb.push_back(mk(0));
    sb.push_back(mk(1));
    sb.push_back(mk(2));
    sb.push_back(mk(3));
    sb.push_back(mk(0));
    req = 4'b1111;
    got = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (grant !== '0) begin
        got++;
        if (got == 5) begin
          req = '0;
          break;
        end
      end
    end
    wait_idle(200, ok);
    checks++;
    if (got != 5 || rise_q.size() != 5) begin
      errors++;
      $display("FAIL rr_count got grants=%0d rises=%0d required 5 5", got, rise_q.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (rise_q[i] - rise_q[i-1] != 2 + 1 + GAP + 1) begin
          errors++;
          $display("FAIL rr_spacing got %0d required %0d",
                   rise_q[i] - rise_q[i-1], 2 + 1 + GAP + 1);
        end
      end
    end
  endtask

  task automatic test_gap_hold;
    bit ok;
    bit din_ok;
    bit idle_seen;
    int at;
    logic [39:0] held;
    held = req_data[39:0];
    sb.push_back(mk(0));
    req[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (grant !== '0) break;
    end
    req[0] = 1'b0;
    req_data[39:0] = ~held;
    din_ok    = 1'b1;
    idle_seen = 1'b0;
    at        = -1;
    for (int k = 1; k < 120; k++) begin
      @(negedge clk);
      if (grant !== '0) begin
        at = k;
        break;
      end
      if (tx_din !== held) din_ok = 1'b0;
      if (k == 75) idle_seen = (busy === 1'b0);
      if (k == 10) begin
        sb.push_back(mk(2));
        req[2] = 1'b1;
      end
    end
    req[2] = 1'b0;
    checks++;
    if (at != 76) begin
      errors++;
      $display("FAIL gap_grant_cycle got %0d required 76", at);
    end
    checks++;
    if (!din_ok) begin
      errors++;
      $display("FAIL gap_din_hold got changed required %h", held);
    end
    checks++;
    if (!idle_seen) begin
      errors++;
      $display("FAIL gap_idle_cycle got busy required idle at cycle 75");
    end
    wait_idle(200, ok);
  endtask

  task automatic test_timeout;
    bit ok;
    bit busy_ok;
    int send_cycles;
    int err_cycles;
    int err_at;
    int at;
    sb.push_back(mk(3));
    sb.push_back(mk(1));
    ack_en = 1'b0;
    req    = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (grant !== '0) break;
    end
    req[3]      = 1'b0;
    send_cycles = (tx_send === 1'b1) ? 1 : 0;
    err_cycles  = 0;
    err_at      = -1;
    at          = -1;
    busy_ok     = 1'b1;
    for (int k = 1; k < 150; k++) begin
      @(negedge clk);
      if (grant !== '0) begin
        at = k;
        break;
      end
      if (tx_send === 1'b1) send_cycles++;
      if (err === 1'b1) begin
        err_cycles++;
        err_at = k;
        ack_en = 1'b1;
      end
      if (k <= 87 && busy !== 1'b1) busy_ok = 1'b0;
    end
    req[1] = 1'b0;
    checks++;
    if (send_cycles != TIMEOUT) begin
      errors++;
      $display("FAIL to_send_len got %0d required %0d", send_cycles, TIMEOUT);
    end
    checks++;
    if (err_cycles != 1 || err_at != TIMEOUT) begin
      errors++;
      $display("FAIL to_err got pulses=%0d at=%0d required 1 at %0d",
               err_cycles, err_at, TIMEOUT);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL to_busy got low required high through gap");
    end
    checks++;
    if (at != TIMEOUT + GAP + 1) begin
      errors++;
      $display("FAIL to_next_grant got %0d required %0d", at, TIMEOUT + GAP + 1);
    end
    wait_idle(200, ok);
  endtask

  task automatic test_clr_send;
    bit ok;
    int got;
    sb.push_back(mk(2));
    req[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (grant !== '0) break;
    end
    req[2] = 1'b0;
    #1;
    clr = 1'b1;
    #1;
    checks++;
    if (tx_send !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_async got send=%b grant=%b busy=%b required 0 0000 0",
               tx_send, grant, busy);
    end
    @(negedge clk);
    clr = 1'b0;
    // Without a pointer reset, requester 3 would win here.
    sb.push_back(mk(0));
    sb.push_back(mk(3));
    req = 4'b1001;
    serve(2, 400, got);
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL clr_restart got %0d grants required 2", got);
    end
    wait_idle(200, ok);
  endtask

  task automatic test_dropped_req;
    bit ok;
    int got;
    int g0;
    g0 = grant_total;
    sb.push_back(mk(1));
    req[1] = 1'b1;
    serve(1, 10, got);
    repeat (5) @(negedge clk);
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    wait_idle(200, ok);
    sb.push_back(mk(2));
    req[2] = 1'b1;
    serve(1, 10, got);
    checks++;
    if (got != 1) begin
      errors++;
      $display("FAIL drop_other got %0d grants required 1", got);
    end
    wait_idle(200, ok);
    @(negedge clk);
    checks++;
    if (grant_total - g0 != 2) begin
      errors++;
      $display("FAIL drop_grants got %0d required 2", grant_total - g0);
    end
  endtask

  initial begin
    clr      = 1'b1;
    req      = '0;
    ack_en   = 1'b1;
    req_data = '0;
    req_id   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_gap_hold();
    test_timeout();
    test_clr_send();
    test_dropped_req();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
